// File: rtl/uart_rx_packer.sv
// -----------------------------------------------------------------------------
// uart_rx_packer
//
// Packs a stream of received UART bytes into NB-byte words for a downstream
// FIFO. Bytes are gathered in an assembly register. A completed word moves to
// a separate output register, which is held until the FIFO accepts it.
// Bytes that arrive while a word waits are still captured. The only exception
// is a byte that would complete a second word while the first one is still
// stalled. That byte is dropped and counted.
//
// Optional feature, guarded by macro UART_RX_PACK_TIMEOUT_EN:
//   In COLLECT, an idle counter flushes a partial word when no byte has
//   arrived for a while. The write strobe then lands TIMEOUT_CYC cycles after
//   the last byte. Without the macro, partial words wait indefinitely and every
//   write carries NB bytes.
//
// Parameters:
//   NB          bytes per FIFO word (1..16)
//   MSB_FIRST   0: first byte in bits [7:0]; 1: first byte in the top byte
//   TIMEOUT_CYC idle cycles before a partial-word flush (2..65535)
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_rx_valid   one-cycle pulse qualifying i_rx_data
//   i_rx_data    received byte
//   i_fifo_full  downstream FIFO full
//   i_clr_ovf    clears o_overflow and o_drop_cnt
//   o_wr_en      FIFO write strobe (WRITE state and FIFO not full)
//   o_wr_data    packed word
//   o_wr_bytes   number of valid bytes in o_wr_data
//   o_overflow   sticky, set when a byte is dropped
//   o_drop_cnt   saturating count of dropped bytes
//   o_busy       assembly register non-empty or FSM not idle
// -----------------------------------------------------------------------------
module uart_rx_packer #(
  parameter int NB          = 4,
  parameter int MSB_FIRST   = 0,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_rx_valid,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_fifo_full,
  input  logic                     i_clr_ovf,
  output logic                     o_wr_en,
  output logic [8*NB-1:0]          o_wr_data,
  output logic [$clog2(NB+1)-1:0]  o_wr_bytes,
  output logic                     o_overflow,
  output logic [15:0]              o_drop_cnt,
  output logic                     o_busy
);

  localparam int W  = 8 * NB;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NB - 1);
  localparam logic [CW-1:0] NB_CNT   = CW'(NB);

  // Parameter sanity: an illegal TIMEOUT_CYC or NB yields an empty marker block.
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 65535) || (NB < 1) || (NB > 16)) begin : g_param_out_of_range
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [W-1:0]    asm_q, asm_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [CW-1:0]   out_bytes_q, out_bytes_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;
  logic            wr_en_s;
  logic            drop_s;
  logic            flush_s;

  // The assembly register is cleared whenever a word leaves it. A partial
  // word therefore always has zeros in its unused upper bytes. MSB_FIRST
  // shifts bytes in from the bottom, so the valid bytes stay right-justified
  // and the first byte ends up topmost.
  function automatic logic [W-1:0] insert_byte(input logic [W-1:0]  acc,
                                               input logic [CW-1:0] idx,
                                               input logic [7:0]    b);
    if (MSB_FIRST != 0) begin
      insert_byte = (acc << 4'd8) | W'(b);
    end else begin
      insert_byte = acc | (W'(b) << {idx, 3'b000});
    end
  endfunction

  assign wr_en_s = (state_q == ST_WRITE) && !i_fifo_full;

`ifdef UART_RX_PACK_TIMEOUT_EN
  // Counts completed idle cycles in COLLECT. It flushes on the cycle that
  // makes the strobe land TIMEOUT_CYC cycles after the last byte.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 2);
  logic [15:0] tmo_q, tmo_d;

  // Idle-cycle counter next state and flush decision.
  always_comb begin
    tmo_d   = 16'd0;
    flush_s = 1'b0;
    if ((state_q == ST_COLLECT) && !i_rx_valid) begin
      if (tmo_q == TMO_LAST) begin
        flush_s = 1'b1;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end else begin
      tmo_d = 16'd0;
    end
  end

  // Idle-cycle counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_q <= 16'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign flush_s = 1'b0;
`endif

  // FSM next state, assembly and output register updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    drop_s      = 1'b0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (i_rx_valid) begin
          if (idx_q == LAST_IDX) begin
            out_data_d  = insert_byte(asm_q, idx_q, i_rx_data);
            out_bytes_d = NB_CNT;
            asm_d       = '0;
            idx_d       = '0;
            state_d     = ST_WRITE;
          end else begin
            asm_d   = insert_byte(asm_q, idx_q, i_rx_data);
            idx_d   = idx_q + CW'(1);
            state_d = ST_COLLECT;
          end
        end else if (flush_s) begin
          out_data_d  = asm_q;
          out_bytes_d = idx_q;
          asm_d       = '0;
          idx_d       = '0;
          state_d     = ST_WRITE;
        end else begin
          state_d = state_q;
        end
      end

      ST_WRITE: begin
        if (i_rx_valid && (idx_q == LAST_IDX)) begin
          if (wr_en_s) begin
            // The held word leaves this cycle, so the new one can replace it.
            out_data_d  = insert_byte(asm_q, idx_q, i_rx_data);
            out_bytes_d = NB_CNT;
            asm_d       = '0;
            idx_d       = '0;
            state_d     = ST_WRITE;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          if (i_rx_valid) begin
            asm_d = insert_byte(asm_q, idx_q, i_rx_data);
            idx_d = idx_q + CW'(1);
          end else begin
            idx_d = idx_q;
          end
          if (wr_en_s) begin
            state_d = (idx_d != '0) ? ST_COLLECT : ST_IDLE;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Overflow flag and drop counter. A drop beats a clear in the same cycle.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop_s) begin
      ovf_d = 1'b1;
      if (i_clr_ovf) begin
        drop_d = 16'd1;
      end else if (drop_q == 16'hFFFF) begin
        drop_d = drop_q;
      end else begin
        drop_d = drop_q + 16'd1;
      end
    end else if (i_clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = 16'd0;
    end else begin
      ovf_d  = ovf_q;
      drop_d = drop_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
    end
  end

  assign o_wr_en    = wr_en_s;
  assign o_wr_data  = out_data_q;
  assign o_wr_bytes = out_bytes_q;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_q;
  assign o_busy     = (state_q != ST_IDLE) || (idx_q != '0);

endmodule
